// File: rtl/tb_ram_port_arbiter.sv
// Shares the testbench RAM data port among NUM_REQ OBI requesters: one grant per cycle, 1-cycle response routing.
// Round-robin by default; define TB_RAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module tb_ram_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*4-1:0]          be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          ram_en_o,
    output logic [ADDR_WIDTH-1:0]         ram_addr_o,
    output logic                          ram_we_o,
    output logic [3:0]                    ram_be_o,
    output logic [DATA_WIDTH-1:0]         ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]         ram_rdata_i,
    output logic [31:0]                   contention_cnt_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic             win_v_s;
    logic [IDX_W-1:0] win_id_s;
    logic             hit_s;
    logic             contend_s;
    logic             resp_v_r;
    logic [IDX_W-1:0] resp_id_r;
    logic [31:0]      cnt_r;

`ifdef TB_RAM_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downward so the final hit is the lowest requesting index.
    always_comb begin
        win_v_s  = 1'b0;
        win_id_s = '0;
        hit_s    = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            hit_s    = req_i[i] & ~rst_i;
            win_id_s = hit_s ? IDX_W'(i) : win_id_s;
            win_v_s  = win_v_s | hit_s;
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W:0]   cand_s;

    // Round-robin: scan candidates rr_ptr+i (mod NUM_REQ) downward so the final hit is the first from rr_ptr.
    always_comb begin
        win_v_s  = 1'b0;
        win_id_s = '0;
        hit_s    = 1'b0;
        cand_s   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_s   = {1'b0, rr_ptr_r} + (IDX_W+1)'(i);
            cand_s   = (cand_s >= (IDX_W+1)'(NUM_REQ)) ? (cand_s - (IDX_W+1)'(NUM_REQ)) : cand_s;
            hit_s    = req_i[cand_s[IDX_W-1:0]] & ~rst_i;
            win_id_s = hit_s ? cand_s[IDX_W-1:0] : win_id_s;
            win_v_s  = win_v_s | hit_s;
        end
    end

    // Pointer moves past the winner; holds when nothing is granted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_r <= '0;
        end else if (win_v_s) begin
            rr_ptr_r <= (win_id_s == IDX_W'(NUM_REQ - 1)) ? '0 : (win_id_s + IDX_W'(1));
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`endif

    // Grant vector and AND-OR mux of the winner's request slices onto the RAM port.
    always_comb begin
        gnt_o       = '0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'b0000;
        ram_wdata_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_o[i]    = win_v_s & (win_id_s == IDX_W'(i));
            ram_addr_o  = ram_addr_o  | (addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]  & {ADDR_WIDTH{gnt_o[i]}});
            ram_we_o    = ram_we_o    | (we_i[i] & gnt_o[i]);
            ram_be_o    = ram_be_o    | (be_i[i*4 +: 4] & {4{gnt_o[i]}});
            ram_wdata_o = ram_wdata_o | (wdata_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_o[i]}});
        end
        ram_en_o = win_v_s;
    end

    // Response tag follows the grant by one cycle, matching the RAM read latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_v_r  <= 1'b0;
            resp_id_r <= '0;
        end else if (win_v_s) begin
            resp_v_r  <= 1'b1;
            resp_id_r <= win_id_s;
        end else begin
            resp_v_r  <= 1'b0;
            resp_id_r <= resp_id_r;
        end
    end

    // Route the response strobe; a pending response is suppressed while reset is held.
    always_comb begin
        rvalid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rvalid_o[i] = resp_v_r & ~rst_i & (resp_id_r == IDX_W'(i));
        end
        rdata_o = ram_rdata_i;
    end

    assign contend_s = ($countones(req_i) >= 32'sd2);

    // Saturating count of cycles in which at least one request lost arbitration.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= 32'h0000_0000;
        end else if (contend_s && (cnt_r != 32'hFFFF_FFFF)) begin
            cnt_r <= cnt_r + 32'h0000_0001;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign contention_cnt_o = cnt_r;

endmodule
